// File: rtl/memory_stage.sv
// MEM stage: EX/MEM register, req/ack data-memory access FSM, branch resolution, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_fault and blocks non-word-aligned accesses.
module memory_stage #(
  parameter int ADDR_W = 10,
  parameter int PC_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [PC_W-1:0]   branch_pc,
  input  logic              zero,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       data2_out,
  input  logic [4:0]        dst,
  output logic              stall,
  output logic              pc_src,
  output logic [PC_W-1:0]   branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [31:0]       wb_read_data,
  output logic [31:0]       wb_alu_result,
  output logic [4:0]        wb_dst
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_fault
`endif
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q, state_d;
  logic              em_valid_q, em_branch_q, em_mem_read_q, em_mem_write_q;
  logic              em_reg_write_q, em_mem_to_reg_q, em_zero_q;
  logic [PC_W-1:0]   em_branch_pc_q;
  logic [31:0]       em_alu_result_q, em_data2_q;
  logic [4:0]        em_dst_q;
  logic              wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q;
  logic [31:0]       wb_read_data_q, wb_alu_result_q;
  logic [4:0]        wb_dst_q;

  logic new_valid, new_access, new_aligned;
  logic em_move, em_misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign new_aligned   = (alu_result[1:0] == 2'b00);
  assign em_misaligned = (em_mem_read_q | em_mem_write_q) & (em_alu_result_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= em_move & em_misaligned;
  end
  assign misalign_fault = misalign_q;
`else
  assign new_aligned   = 1'b1;
  assign em_misaligned = 1'b0;
`endif

  assign stall         = (state_q == ACCESS) & ~dmem_ack;
  assign pc_src        = em_valid_q & em_branch_q & em_zero_q & (state_q == IDLE);
  assign branch_target = em_branch_pc_q;

  // A taken branch squashes whatever EX presents during its pc_src cycle.
  assign new_valid  = in_valid & ~pc_src;
  assign new_access = new_valid & (mem_read | mem_write) & new_aligned;

  // A valid entry leaves EX/MEM when idle (non-memory or trapped) or on its ack edge.
  assign em_move = em_valid_q & ((state_q == IDLE) | dmem_ack);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (!stall) state_d = new_access ? ACCESS : IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      em_valid_q      <= 1'b0;
      em_branch_q     <= 1'b0;
      em_mem_read_q   <= 1'b0;
      em_mem_write_q  <= 1'b0;
      em_reg_write_q  <= 1'b0;
      em_mem_to_reg_q <= 1'b0;
      em_zero_q       <= 1'b0;
      em_branch_pc_q  <= '0;
      em_alu_result_q <= '0;
      em_data2_q      <= '0;
      em_dst_q        <= '0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        em_valid_q      <= new_valid;
        em_branch_q     <= branch;
        em_mem_read_q   <= mem_read;
        em_mem_write_q  <= mem_write;
        em_reg_write_q  <= reg_write;
        em_mem_to_reg_q <= mem_to_reg;
        em_zero_q       <= zero;
        em_branch_pc_q  <= branch_pc;
        em_alu_result_q <= alu_result;
        em_data2_q      <= data2_out;
        em_dst_q        <= dst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_dst_q        <= '0;
    end else begin
      wb_valid_q     <= em_move;
      wb_reg_write_q <= em_move & em_reg_write_q & ~em_misaligned;
      if (em_move) begin
        wb_mem_to_reg_q <= em_mem_to_reg_q;
        wb_alu_result_q <= em_alu_result_q;
        wb_dst_q        <= em_dst_q;
        // Read+write together behaves as a store, so only a pure load returns data.
        wb_read_data_q  <= (state_q == ACCESS && em_mem_read_q && !em_mem_write_q) ? dmem_rdata : 32'h0;
      end
    end
  end

  // Request lines come straight from registers and so cannot change until the ack edge.
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = em_mem_write_q;
  assign dmem_addr  = em_alu_result_q[ADDR_W+1:2];
  assign dmem_wdata = em_data2_q;

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_dst        = wb_dst_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table of single-instruction vectors plus
// hand-written stall, squash, reset-abort and misalignment sequences.
module tb_memory_stage;

  logic        clk, rst_n;
  logic        in_valid, branch, mem_read, mem_write, reg_write, mem_to_reg, zero;
  logic [6:0]  branch_pc;
  logic [31:0] alu_result, data2_out;
  logic [4:0]  dst;
  logic        stall, pc_src;
  logic [6:0]  branch_target;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_dst;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  int n_total = 0;
  int n_pass  = 0;

  memory_stage #(.ADDR_W(10), .PC_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .branch_pc(branch_pc), .zero(zero),
    .alu_result(alu_result), .data2_out(data2_out), .dst(dst),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_dst(wb_dst)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_fault(misalign_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, branch, rd, wr, rw, m2r, zero;
    logic [6:0]  bpc;
    logic [31:0] alu, d2;
    logic [4:0]  dst;
  } op_t;

  typedef struct {
    op_t         op;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_pc_src;
    logic [6:0]  e_tgt;
    logic        e_wb_valid, e_wb_rw, e_wb_m2r;
    logic [31:0] e_wb_rd, e_wb_alu;
    logic [4:0]  e_wb_dst;
  } vec_t;

  vec_t vecs[9];

  function automatic op_t mk_op(logic v, logic b, logic rd, logic wr, logic rw, logic m2r,
                                logic z, logic [6:0] bpc, logic [31:0] alu, logic [31:0] d2,
                                logic [4:0] d);
    op_t o;
    o.valid = v; o.branch = b; o.rd = rd; o.wr = wr; o.rw = rw; o.m2r = m2r;
    o.zero = z; o.bpc = bpc; o.alu = alu; o.d2 = d2; o.dst = d;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input op_t o);
    in_valid = o.valid; branch = o.branch; mem_read = o.rd; mem_write = o.wr;
    reg_write = o.rw; mem_to_reg = o.m2r; zero = o.zero; branch_pc = o.bpc;
    alu_result = o.alu; data2_out = o.d2; dst = o.dst;
  endtask

  task automatic idle();
    apply(mk_op(0, 0, 0, 0, 0, 0, 0, 7'h0, 32'h0, 32'h0, 5'h0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_stall;

    //             op                                                          ack  rdata         req we addr    wdata       pc tgt    wbv rw m2r rd            alu           dst
    vecs[0] = '{mk_op(1,0,0,0,1,0,0,7'h00,32'h55,32'h0,5'd3),          1'b0, 32'h0,        1'b0,1'b0,10'h0, 32'h0,      1'b0,7'h0, 1'b1,1'b1,1'b0,32'h0,       32'h55,       5'd3};
    vecs[1] = '{mk_op(1,0,0,1,0,0,0,7'h00,32'h8,32'hCAFE,5'd0),        1'b1, 32'h1111,     1'b1,1'b1,10'h2, 32'hCAFE,   1'b0,7'h0, 1'b1,1'b0,1'b0,32'h0,       32'h8,        5'd0};
    vecs[2] = '{mk_op(1,0,1,0,1,1,0,7'h00,32'h40,32'h0,5'd7),          1'b1, 32'h12345678, 1'b1,1'b0,10'h10,32'h0,      1'b0,7'h0, 1'b1,1'b1,1'b1,32'h12345678,32'h40,       5'd7};
    vecs[3] = '{mk_op(1,0,1,0,1,1,0,7'h00,32'hFFFF_F004,32'h0,5'd8),   1'b1, 32'hA5A5A5A5, 1'b1,1'b0,10'h1, 32'h0,      1'b0,7'h0, 1'b1,1'b1,1'b1,32'hA5A5A5A5,32'hFFFF_F004,5'd8};
    vecs[4] = '{mk_op(1,0,1,1,0,0,0,7'h00,32'h100,32'h77,5'd0),        1'b1, 32'h99,       1'b1,1'b1,10'h40,32'h77,     1'b0,7'h0, 1'b1,1'b0,1'b0,32'h0,       32'h100,      5'd0};
    vecs[5] = '{mk_op(0,0,1,0,1,1,0,7'h00,32'h40,32'h0,5'd4),          1'b0, 32'h0,        1'b0,1'b0,10'h0, 32'h0,      1'b0,7'h0, 1'b0,1'b0,1'b0,32'h0,       32'h0,        5'd0};
    vecs[6] = '{mk_op(1,1,0,0,0,0,0,7'h11,32'h5,32'h0,5'd0),           1'b0, 32'h0,        1'b0,1'b0,10'h0, 32'h0,      1'b0,7'h0, 1'b1,1'b0,1'b0,32'h0,       32'h5,        5'd0};
    vecs[7] = '{mk_op(1,1,0,0,0,0,1,7'h2A,32'h0,32'h0,5'd0),           1'b0, 32'h0,        1'b0,1'b0,10'h0, 32'h0,      1'b1,7'h2A,1'b1,1'b0,1'b0,32'h0,       32'h0,        5'd0};
    vecs[8] = '{mk_op(1,0,0,0,1,0,0,7'h00,32'h1234,32'h0,5'd31),       1'b1, 32'hFFFF,     1'b0,1'b0,10'h0, 32'h0,      1'b0,7'h0, 1'b1,1'b1,1'b0,32'h0,       32'h1234,     5'd31};

    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    idle();
    #2;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_pc_src", {31'h0, pc_src}, 32'h0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_wb_alu", wb_alu_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].op);
      @(posedge clk);
      @(negedge clk);
      idle();
      dmem_ack = vecs[i].ack; dmem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
      check($sformatf("v%0d_req", i), {31'h0, dmem_req}, {31'h0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_we", i), {31'h0, dmem_we}, {31'h0, vecs[i].e_we});
        check($sformatf("v%0d_addr", i), {22'h0, dmem_addr}, {22'h0, vecs[i].e_addr});
        if (vecs[i].e_we) check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
      end
      check($sformatf("v%0d_pc_src", i), {31'h0, pc_src}, {31'h0, vecs[i].e_pc_src});
      if (vecs[i].e_pc_src) check($sformatf("v%0d_tgt", i), {25'h0, branch_target}, {25'h0, vecs[i].e_tgt});
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      check($sformatf("v%0d_wb_valid", i), {31'h0, wb_valid}, {31'h0, vecs[i].e_wb_valid});
      check($sformatf("v%0d_wb_rw", i), {31'h0, wb_reg_write}, {31'h0, vecs[i].e_wb_rw});
      if (vecs[i].e_wb_valid) begin
        check($sformatf("v%0d_wb_m2r", i), {31'h0, wb_mem_to_reg}, {31'h0, vecs[i].e_wb_m2r});
        check($sformatf("v%0d_wb_rd", i), wb_read_data, vecs[i].e_wb_rd);
        check($sformatf("v%0d_wb_alu", i), wb_alu_result, vecs[i].e_wb_alu);
        check($sformatf("v%0d_wb_dst", i), {27'h0, wb_dst}, {27'h0, vecs[i].e_wb_dst});
      end
    end

    // Load with ack in the third request cycle; an ALU op waits behind it.
    apply(mk_op(1,0,1,0,1,1,0,7'h0,32'h10,32'h0,5'd2));
    @(posedge clk);
    @(negedge clk);
    apply(mk_op(1,0,0,0,1,0,0,7'h0,32'h99,32'h0,5'd9));
    n_stall = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      #1;
      if (stall) n_stall++;
      check($sformatf("ld_req_c%0d", c), {31'h0, dmem_req}, 32'h1);
      check($sformatf("ld_wbv_c%0d", c), {31'h0, wb_valid}, 32'h0);
      if (c == 1) begin
        check("ld_addr", {22'h0, dmem_addr}, 32'h4);
        check("ld_we", {31'h0, dmem_we}, 32'h0);
      end
      if (c < 3) next_cycle();
    end
    check("ld_stall_cycles", n_stall, 2);
    next_cycle();
    idle(); dmem_ack = 1'b0;
    #1;
    check("ld_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("ld_wb_rdata", wb_read_data, 32'hDEADBEEF);
    check("ld_wb_rw", {31'h0, wb_reg_write}, 32'h1);
    check("ld_wb_dst", {27'h0, wb_dst}, 32'd2);
    check("ld_req_drop", {31'h0, dmem_req}, 32'h0);
    next_cycle();
    #1;
    check("held_alu_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("held_alu_wb_alu", wb_alu_result, 32'h99);
    check("held_alu_wb_dst", {27'h0, wb_dst}, 32'd9);
    check("held_alu_wb_rd", wb_read_data, 32'h0);

    // Taken branch squashes the load presented during its pc_src cycle.
    next_cycle();
    apply(mk_op(1,1,0,0,0,0,1,7'h2A,32'h0,32'h0,5'd0));
    @(posedge clk);
    @(negedge clk);
    apply(mk_op(1,0,1,0,1,1,0,7'h0,32'h30,32'h0,5'd5));
    #1;
    check("sq_pc_src", {31'h0, pc_src}, 32'h1);
    check("sq_tgt", {25'h0, branch_target}, 32'h2A);
    next_cycle();
    idle();
    #1;
    check("sq_pc_src_drop", {31'h0, pc_src}, 32'h0);
    check("sq_req", {31'h0, dmem_req}, 32'h0);
    check("sq_branch_wbv", {31'h0, wb_valid}, 32'h1);
    next_cycle();
    #1;
    check("sq_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("sq_wb_rw", {31'h0, wb_reg_write}, 32'h0);

    // Reset while a load is outstanding, then a late ack.
    apply(mk_op(1,0,1,0,1,1,0,7'h0,32'h20,32'h0,5'd6));
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check("ra_req", {31'h0, dmem_req}, 32'h1);
    check("ra_stall", {31'h0, stall}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ra_req_drop", {31'h0, dmem_req}, 32'h0);
    check("ra_stall_drop", {31'h0, stall}, 32'h0);
    check("ra_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("ra_wb_alu", wb_alu_result, 32'h0);
    check("ra_wb_dst", {27'h0, wb_dst}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD;
    #1;
    check("ra_late_stall", {31'h0, stall}, 32'h0);
    check("ra_late_req", {31'h0, dmem_req}, 32'h0);
    next_cycle();
    dmem_ack = 1'b0;
    #1;
    check("ra_late_wbv", {31'h0, wb_valid}, 32'h0);
    check("ra_late_rd", wb_read_data, 32'h0);

    // Load at byte address 0x13.
    apply(mk_op(1,0,1,0,1,1,0,7'h0,32'h13,32'h0,5'd6));
    @(posedge clk);
    @(negedge clk);
    idle();
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    check("mis_req", {31'h0, dmem_req}, 32'h0);
    check("mis_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    #1;
    check("mis_fault", {31'h0, misalign_fault}, 32'h1);
    check("mis_wbv", {31'h0, wb_valid}, 32'h1);
    check("mis_wb_rw", {31'h0, wb_reg_write}, 32'h0);
    next_cycle();
    #1;
    check("mis_fault_drop", {31'h0, misalign_fault}, 32'h0);
`else
    dmem_ack = 1'b1; dmem_rdata = 32'h5A;
    #1;
    check("mis_req", {31'h0, dmem_req}, 32'h1);
    check("mis_addr", {22'h0, dmem_addr}, 32'h4);
    next_cycle();
    dmem_ack = 1'b0;
    #1;
    check("mis_wb_rd", wb_read_data, 32'h5A);
    check("mis_wb_rw", {31'h0, wb_reg_write}, 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
